// File: rtl/panel_input_ctrl.sv
// Front-panel input conditioning: 2-flop synchronisers, per-bit debounce,
// key/mode-change pulse generation and the manual-entry address counter.
module panel_input_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       A1,
    input  logic [7:0] D,
    output logic [1:0] cpustate,
    output logic       a1_pulse,
    output logic [7:0] d_out,
    output logic [7:0] panel_addr,
    output logic       mode_chg
);

    localparam int NB = 11;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'b00,
        ST_CHECK = 2'b01,
        ST_RUN   = 2'b10
    } mode_e;

    // Bit map: [10]=SW1, [9]=SW2, [8]=A1, [7:0]=D
    logic [NB-1:0] raw_in;
    logic [NB-1:0] sync1_reg;
    logic [NB-1:0] sync2_reg;
    logic [NB-1:0] stable;

    assign raw_in = {SW1, SW2, A1, D};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= raw_in;
            sync2_reg <= sync1_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_deb
            logic [CNT_W-1:0] cnt_reg;
            logic             stable_reg;

            // Any cycle where the synced bit agrees with the stable value
            // restarts the count, so short glitches never commit.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else if (sync2_reg[gi] == stable_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
                    stable_reg <= sync2_reg[gi];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign stable[gi] = stable_reg;
        end
    endgenerate

    assign cpustate = stable[10:9];
    assign d_out    = stable[7:0];

    logic       a1_prev_reg;
    logic [1:0] mode_prev_reg;
    logic       a1_pulse_reg;
    logic       mode_chg_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a1_prev_reg   <= 1'b0;
            mode_prev_reg <= 2'b00;
            a1_pulse_reg  <= 1'b0;
            mode_chg_reg  <= 1'b0;
        end else begin
            a1_prev_reg   <= stable[8];
            mode_prev_reg <= stable[10:9];
            a1_pulse_reg  <= stable[8] & ~a1_prev_reg;
            mode_chg_reg  <= (stable[10:9] != mode_prev_reg);
        end
    end

    assign a1_pulse = a1_pulse_reg;
    assign mode_chg = mode_chg_reg;

    mode_e      state_reg;
    mode_e      state_next;
    logic [7:0] addr_reg;
    logic [7:0] addr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_LOAD;
            addr_reg  <= 8'h00;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    // Clear on mode change takes priority over a coincident key increment.
    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        case (cpustate)
            2'b00:   state_next = ST_LOAD;
            2'b01:   state_next = ST_CHECK;
            default: state_next = ST_RUN;
        endcase
        if (mode_chg_reg) begin
            addr_next = 8'h00;
        end else if (a1_pulse_reg && (state_reg != ST_RUN)) begin
            addr_next = addr_reg + 8'h01;
        end
    end

    assign panel_addr = addr_reg;

endmodule

// File: doc/panel_input_ctrl.md
Name: panel_input_ctrl

Overview:
- Front-panel conditioning stage directly upstream of the CPU state controller and RAM manual-entry path.
- Synchronises and debounces the raw board inputs: mode switches SW1/SW2, key A1 and data switches D.
- Produces a clean CPU mode code, a single-cycle key pulse, stable switch data, a mode-change strobe and an 8-bit panel address counter for manual load/check.
- All downstream panel consumers take these conditioned signals instead of raw pins.

Parameters:
DEB_CYCLES, 4, consecutive clk cycles a synchronised input must differ from its stable value before the stable value updates. Synthesis builds override this with a large value (e.g. 1000000).
CNT_W, 20, width of each debounce counter; must hold DEB_CYCLES-1.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
SW1  input  1  raw mode switch, high bit
SW2  input  1  raw mode switch, low bit
A1  input  1  raw key, pressed = 1
D  input  8  raw data switches
cpustate  output  2  debounced mode, {SW1,SW2}: 00 load, 01 check, 10/11 run
a1_pulse  output  1  one-cycle pulse on debounced A1 press
d_out  output  8  debounced D
panel_addr  output  8  manual-entry address
mode_chg  output  1  one-cycle pulse when cpustate changes

Behaviour:
- Reset (rst=0, asynchronous): all synchronisers, stable values, counters and outputs go to 0. cpustate=00, panel_addr=0, pulses=0. Reset mid-debounce discards partial counts.
- Synchronisers: every input bit passes through a 2-flop synchroniser.
- Debounce groups: SW1, SW2, A1 and each D bit are debounced independently, giving 11 counters.
- Per-bit debounce, per cycle:
  - If the synced value equals the stable value, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter equals DEB_CYCLES-1 and the mismatch persists, the stable value takes the synced value and the counter clears.
- Debounce latency: a clean input step appears on the stable output DEB_CYCLES+2 rising edges after the step is sampled.
- Glitch rejection: a glitch shorter than DEB_CYCLES synced cycles never changes the stable value.
- cpustate is the registered {SW1_stable, SW2_stable}.
- mode_chg is asserted for exactly one cycle, the cycle after cpustate takes a new value. It stays low if only one switch bounces back before debounce completes.
- a1_pulse is high for exactly one cycle on a 0->1 transition of A1_stable. Holding the key gives no further pulses. Release gives no pulse.
- panel_addr FSM, with modes LOAD(00), CHECK(01), RUN(1x):
  - LOAD/CHECK: each a1_pulse increments panel_addr, wrapping 8'hFF -> 8'h00.
  - RUN: panel_addr holds. a1_pulse is still emitted and serves as the run/step request.
  - Any mode_chg cycle clears panel_addr to 0.
  - If a1_pulse and mode_chg occur in the same cycle, the clear wins (result 0, no increment). a1_pulse is still output.
- d_out: changes bit-wise as each bit settles, with no word-level coherence. Consumers sample d_out on a1_pulse.
- Output registering: all outputs are registered with no combinational path from inputs.

Test Plan:
- Reset then release with all inputs 0 -> cpustate=00, panel_addr=0, d_out=00, a1_pulse=0, mode_chg=0 for 20 cycles.
- Set D=8'hA5 and hold (DEB_CYCLES=4) -> d_out=8'hA5 exactly 6 edges later. A 3-cycle D=8'hFF glitch afterwards leaves d_out=8'hA5.
- In LOAD, press A1 clean for 10 cycles, release, repeat 3 times -> three single-cycle a1_pulse; panel_addr 0->1->2->3.
- Preload panel_addr=8'hFF via 255 presses, press once more -> panel_addr=8'h00.
- Bounce A1 as 1,0,1,0 with 2-cycle widths, then hold 1 -> exactly one a1_pulse and one increment.
- Switch SW1=1 (RUN) with addr=5 -> one mode_chg pulse and panel_addr=0. A1 press in RUN gives a1_pulse and panel_addr stays 0. Assert rst=0 mid-debounce of SW2 -> all outputs 0 immediately.
